// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
//   Signal bundle between the reset sequencer and the logic around it.
//
//   Parameter
//     STAGES      number of active-low reset domains (1..8)
//
//   Signals
//     pll_locked  PLL lock indication, asynchronous to sysclk
//     soft_rst_n  soft reset button, active-low, asynchronous, bouncy
//     rst_n       per-domain active-low resets, released index 0 first
//     seq_busy    high while any rst_n bit is low
//     seq_done    one-cycle pulse when the last domain is released
//     stage_idx   number of domains currently released
//
//   Modports
//     master      the sequencer (samples inputs, drives resets and status)
//     slave       the environment (drives inputs, observes resets and status)
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    localparam int IDX_W = $clog2(STAGES + 1);

    logic              pll_locked;
    logic              soft_rst_n;
    logic [STAGES-1:0] rst_n;
    logic              seq_busy;
    logic              seq_done;
    logic [IDX_W-1:0]  stage_idx;

    modport master (
        input  pll_locked,
        input  soft_rst_n,
        output rst_n,
        output seq_busy,
        output seq_done,
        output stage_idx
    );

    modport slave (
        output pll_locked,
        output soft_rst_n,
        input  rst_n,
        input  seq_busy,
        input  seq_done,
        input  stage_idx
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Power-on / soft-reset sequencer. Waits for PLL lock, then releases STAGES
//   active-low reset domains one after another: domain 0 INIT_DLY cycles after
//   the start condition, each further domain STAGE_DLY cycles after the
//   previous one. Loss of lock or an accepted (debounced) soft reset aborts
//   the sequence, pulls every domain back into reset and starts over.
//
//   Parameters
//     STAGES     number of reset domains, 1..8
//     INIT_DLY   cycles from start condition to release of domain 0 (>=1)
//     STAGE_DLY  cycles between consecutive domain releases (>=1)
//     SOFT_MIN   consecutive low samples needed to accept a soft reset (>=1)
//     CNT_W      width of the delay and soft-filter counters
//
//   Ports
//     sysclk     system clock
//     reset1     asynchronous active-low master reset
//     bus        reset_sequencer_if.master (pll_locked, soft_rst_n in;
//                rst_n, seq_busy, seq_done, stage_idx out)
//
//   The interface instance must be built with the same STAGES value.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int STAGES    = 3,
    parameter int INIT_DLY  = 200,
    parameter int STAGE_DLY = 200,
    parameter int SOFT_MIN  = 4,
    parameter int CNT_W     = 11
) (
    input  logic               sysclk,
    input  logic               reset1,
    reset_sequencer_if.master  bus
);

    localparam int IDX_W   = $clog2(STAGES + 1);
    localparam int MAX_DLY = (INIT_DLY > STAGE_DLY)
                           ? ((INIT_DLY > SOFT_MIN) ? INIT_DLY : SOFT_MIN)
                           : ((STAGE_DLY > SOFT_MIN) ? STAGE_DLY : SOFT_MIN);

    // Parameter sanity checks, evaluated at elaboration.
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("reset_sequencer: STAGES must be in 1..8");
    end
    if (INIT_DLY < 1 || STAGE_DLY < 1 || SOFT_MIN < 1) begin : g_bad_delay
        $error("reset_sequencer: INIT_DLY, STAGE_DLY and SOFT_MIN must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_DLY)) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W too narrow for the configured delays");
    end

    localparam logic [CNT_W-1:0] C_INIT     = CNT_W'(INIT_DLY);
    localparam logic [CNT_W-1:0] C_STAGE    = CNT_W'(STAGE_DLY);
    localparam logic [CNT_W-1:0] C_SOFT     = CNT_W'(SOFT_MIN);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(STAGES - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_STAGE = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers, bit 0 = pll_locked, bit 1 = soft_rst_n.
    // Both reset to 0, so a soft reset can look pending for a few cycles after
    // reset1 releases; SOFT_MIN filtering normally hides that.
    // -------------------------------------------------------------------------
    logic [1:0] w_async_in;
    logic [1:0] r_sync_meta;
    logic [1:0] r_sync_out;

    assign w_async_in = {bus.soft_rst_n, bus.pll_locked};

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            r_sync_meta <= 2'b00;
            r_sync_out  <= 2'b00;
        end else begin
            r_sync_meta <= w_async_in;
            r_sync_out  <= r_sync_meta;
        end
    end

    logic w_locked_s;
    logic w_soft_s;
    assign w_locked_s = r_sync_out[0];
    assign w_soft_s   = r_sync_out[1];

    // -------------------------------------------------------------------------
    // Soft-reset filter: counts consecutive low samples, saturating at
    // SOFT_MIN; the request holds while saturated and drops on the first
    // high sample.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_soft_cnt;
    logic             w_soft_req;
    logic             w_go;

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            r_soft_cnt <= '0;
        end else if (w_soft_s) begin
            r_soft_cnt <= '0;
        end else if (r_soft_cnt != C_SOFT) begin
            r_soft_cnt <= r_soft_cnt + C_ONE;
        end
    end

    assign w_soft_req = (r_soft_cnt == C_SOFT);
    assign w_go       = w_locked_s & ~w_soft_req;

    // -------------------------------------------------------------------------
    // Sequencing state machine
    // -------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [STAGES-1:0] r_rst_n;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [STAGES-1:0] w_rst_n_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_done_next;
    logic              w_busy_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rst_n_next = r_rst_n;
        w_idx_next   = r_idx;
        w_done_next  = 1'b0;

        if (r_state != S_WAIT && !w_go) begin
            // Abort wins over any release due on this edge; a partial
            // sequence is never resumed, the next attempt starts from INIT.
            w_state_next = S_WAIT;
            w_cnt_next   = '0;
            w_rst_n_next = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    w_cnt_next   = '0;
                    w_rst_n_next = '0;
                    w_idx_next   = '0;
                    if (w_go) begin
                        // Counter holds the number of INIT cycles elapsed,
                        // so domain 0 is released exactly INIT_DLY edges on.
                        w_state_next = S_INIT;
                        w_cnt_next   = C_ONE;
                    end
                end
                S_INIT: begin
                    if (r_cnt == C_INIT) begin
                        w_rst_n_next = STAGES'(1);
                        w_idx_next   = C_IDX_ONE;
                        if (STAGES == 1) begin
                            w_state_next = S_RUN;
                            w_cnt_next   = '0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = S_STAGE;
                            w_cnt_next   = C_ONE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
                S_STAGE: begin
                    if (r_cnt == C_STAGE) begin
                        // Shifting a 1 in from the bottom keeps releases in
                        // index order.
                        w_rst_n_next = (r_rst_n << 1) | STAGES'(1);
                        w_idx_next   = r_idx + C_IDX_ONE;
                        w_cnt_next   = C_ONE;
                        if (r_idx == C_LAST_IDX) begin
                            w_state_next = S_RUN;
                            w_cnt_next   = '0;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
                S_RUN: begin
                    w_cnt_next = '0;
                end
                default: begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                    w_rst_n_next = '0;
                    w_idx_next   = '0;
                end
            endcase
        end

        // Busy is derived from the next reset vector so it moves on the
        // same edge as rst_n.
        w_busy_next = ~&w_rst_n_next;
    end

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rst_n <= w_rst_n_next;
            r_idx   <= w_idx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.rst_n     = r_rst_n;
    assign bus.seq_busy  = r_busy;
    assign bus.seq_done  = r_done;
    assign bus.stage_idx = r_idx;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer. Two instances share the stimulus:
//   dut3 (STAGES=3) and dut1 (STAGES=1), both with INIT_DLY=8, STAGE_DLY=4,
//   SOFT_MIN=3. Inputs change 1 time unit after a rising edge and outputs are
//   sampled at that same point, i.e. they reflect the state after the edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int INIT_DLY  = 8;
    localparam int STAGE_DLY = 4;

    logic sysclk     = 1'b0;
    logic reset1     = 1'b1;
    logic pll_locked = 1'b1;
    logic soft_rst_n = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sysclk = ~sysclk;

    reset_sequencer_if #(.STAGES(3)) bus3 ();
    reset_sequencer_if #(.STAGES(1)) bus1 ();

    assign bus3.pll_locked = pll_locked;
    assign bus3.soft_rst_n = soft_rst_n;
    assign bus1.pll_locked = pll_locked;
    assign bus1.soft_rst_n = soft_rst_n;

    reset_sequencer #(
        .STAGES(3), .INIT_DLY(INIT_DLY), .STAGE_DLY(STAGE_DLY),
        .SOFT_MIN(3), .CNT_W(4)
    ) dut3 (
        .sysclk(sysclk),
        .reset1(reset1),
        .bus   (bus3)
    );

    reset_sequencer #(
        .STAGES(1), .INIT_DLY(INIT_DLY), .STAGE_DLY(STAGE_DLY),
        .SOFT_MIN(3), .CNT_W(4)
    ) dut1 (
        .sysclk(sysclk),
        .reset1(reset1),
        .bus   (bus1)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Number of domains released j edges after the start edge E (STAGES=3).
    function automatic int exp_k3(input int j);
        int k;
        if (j < INIT_DLY) return 0;
        k = (j - INIT_DLY) / STAGE_DLY + 1;
        if (k > 3) k = 3;
        return k;
    endfunction

    task automatic check_fixed(input string tag, input int rst, input int busy,
                               input int done, input int idx);
        $display("%-8s t=%0t rst_n=%b busy=%b done=%b idx=%0d", tag, $time,
                 bus3.rst_n, bus3.seq_busy, bus3.seq_done, bus3.stage_idx);
        check_val({tag, ".rst_n"}, int'(bus3.rst_n),     rst);
        check_val({tag, ".busy"},  int'(bus3.seq_busy),  busy);
        check_val({tag, ".done"},  int'(bus3.seq_done),  done);
        check_val({tag, ".idx"},   int'(bus3.stage_idx), idx);
    endtask

    // Check dut3 (and optionally dut1) against an uninterrupted sequence
    // whose start edge E lies j edges back (j<0: not started yet).
    task automatic check_seq(input string tag, input int j, input bit with1);
        int k;
        k = exp_k3(j);
        check_fixed(tag, (1 << k) - 1, (k < 3) ? 1 : 0,
                    (j == INIT_DLY + 2 * STAGE_DLY) ? 1 : 0, k);
        if (with1) begin
            check_val({tag, ".s1_rst_n"}, int'(bus1.rst_n),     (j >= INIT_DLY) ? 1 : 0);
            check_val({tag, ".s1_busy"},  int'(bus1.seq_busy),  (j >= INIT_DLY) ? 0 : 1);
            check_val({tag, ".s1_done"},  int'(bus1.seq_done),  (j == INIT_DLY) ? 1 : 0);
            check_val({tag, ".s1_idx"},   int'(bus1.stage_idx), (j >= INIT_DLY) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset values, before any clock edge.
        #1 reset1 = 1'b0;
        #2;
        check_fixed("reset", 0, 1, 0, 0);
        check_val("reset.s1_busy", int'(bus1.seq_busy), 1);
        tick();
        tick();
        check_fixed("reset2", 0, 1, 0, 0);
        reset1 = 1'b1;

        // Power-up: first edge after release is edge 0, locked_s seen at
        // edge 2 (E=2), releases at 10/14/18.
        for (int e = 0; e < 20; e++) begin
            tick();
            check_seq("pwrup", e - 2, 1'b1);
        end

        // Soft reset held for 2 samples: filtered out.
        soft_rst_n = 1'b0;
        tick();
        tick();
        soft_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_fixed("soft2", 7, 0, 0, 3);
        end

        // Soft reset held for 3 samples: abort 6 edges later, restart at +7.
        soft_rst_n = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (j <= 5) check_fixed("soft3", 7, 0, 0, 3);
            else        check_seq("soft3", j - 7, 1'b0);
            if (j == 3) soft_rst_n = 1'b1;
        end

        // Lock loss while rst_n=001: all domains back in reset 3 edges later.
        pll_locked = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            tick();
            if (m < 3) check_seq("lol", INIT_DLY + m, 1'b0);
            else       check_fixed("lol", 0, 1, 0, 0);
        end

        // Relock: full sequence from domain 0.
        pll_locked = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            check_seq("relock", n - 3, 1'b0);
        end

        // Lock loss on the edge where the second release is due.
        pll_locked = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n < 3) check_fixed("drop", 7, 0, 0, 3);
            else       check_fixed("drop", 0, 1, 0, 0);
        end
        pll_locked = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n <= 14) check_seq("coinc", n - 3, 1'b0);
            else         check_fixed("coinc", 0, 1, 0, 0);
            if (n == 12) pll_locked = 1'b0;
        end

        // Relock and stop mid-STAGE (rst_n=011), then assert reset1 between
        // edges: outputs must clear without a clock edge.
        pll_locked = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check_seq("stage", n - 3, 1'b0);
        end
        #2 reset1 = 1'b0;
        #1;
        check_fixed("async", 0, 1, 0, 0);
        tick();
        check_fixed("async2", 0, 1, 0, 0);
        reset1 = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check_seq("restart", e - 2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and soft-reset sequencer for the synthesizer top level. It replaces the fixed MCNT counter and single-threshold reset compare with a state machine. The machine waits for PLL lock, then releases a configurable number of active-low reset domains one after another with programmable spacing. It re-sequences on PLL lock loss or on a debounced soft-reset button, and reports progress to the LEDs and downstream logic.

## Interface
- STAGES, 3: number of reset domains released in order, index 0 first. Range 1..8.
- INIT_DLY, 200: sysclk cycles from lock-and-no-soft-reset to release of domain 0. Must be ≥1.
- STAGE_DLY, 200: sysclk cycles between release of domain k-1 and domain k. Must be ≥1.
- SOFT_MIN, 4: consecutive synchronised-low cycles on soft_rst_n needed to accept a soft reset. Must be ≥1.
- CNT_W, 11: delay counter width. Elaboration error if 2^CNT_W ≤ max(INIT_DLY, STAGE_DLY, SOFT_MIN).
- sysclk  in  1  system clock.
- reset1  in  1  asynchronous active-low master reset.
- pll_locked  in  1  PLL lock, asynchronous to sysclk.
- soft_rst_n  in  1  soft reset button, active-low, asynchronous, bouncy.
- rst_n  out  STAGES  per-domain active-low resets, registered.
- seq_busy  out  1  high while any rst_n bit is low.
- seq_done  out  1  one-cycle pulse when the last domain is released.
- stage_idx  out  utils::clogb2(STAGES+1)  number of domains currently released.

## Operation
- Synchronisers: pll_locked and soft_rst_n each pass through two flops, reset to 0, giving locked_s and soft_s.
- Soft filter: a counter increments while soft_s=0 and clears when soft_s=1. It saturates at SOFT_MIN. soft_req is high while count==SOFT_MIN.
- go = locked_s & ~soft_req.
- State machine states:
  - WAIT: all rst_n=0, counter cleared. When go=1, move to INIT.
  - INIT: counter counts from 1. When go=1 and count reaches INIT_DLY, set rst_n[0]=1 and stage_idx=1, then move to RUN if STAGES==1, otherwise to STAGE.
  - STAGE: counter restarts at each release. When count reaches STAGE_DLY, release the next domain and increment stage_idx. After the last domain is released, move to RUN.
  - RUN: idle; all rst_n=1.
- Abort: if go=0 in INIT, STAGE or RUN, then on the next edge all rst_n=0, stage_idx=0, counter=0, and state=WAIT. Abort has priority over any release due on the same edge.
- Domains are never released out of order. A partial sequence is never resumed; each restart begins from INIT.
- seq_done is asserted on the same edge that raises rst_n[STAGES-1]. It is not asserted on an aborted sequence.
- seq_busy = ~&rst_n, registered so that it changes on the same edge as rst_n.

## Timing
- Reset values (reset1=0): rst_n=0, seq_busy=1, seq_done=0, stage_idx=0, state=WAIT, synchronisers 0, counters 0.
- When reset1 is deasserted, outputs stay at their reset values until the sequence runs.
- Input latency: 2 edges from an input change to locked_s/soft_s. Soft reset accepted SOFT_MIN edges after soft_s falls.
- Let edge E be the first edge with go=1 sampled in WAIT; state is INIT from E+1.
  - rst_n[0] rises at edge E+INIT_DLY.
  - rst_n[k] rises at edge E+INIT_DLY+k·STAGE_DLY.
- Abort latency: 1 edge after go falls. From a pll_locked fall to rst_n=0: 3 edges.
- Asserting reset1 mid-sequence clears all outputs immediately (asynchronous). Release is synchronous to sysclk through the normal sequence.

## Test plan
- Power-up (STAGES=3, INIT_DLY=8, STAGE_DLY=4, SOFT_MIN=3), pll_locked held high, reset1 released before edge 0 -> locked_s high at edge 2; rst_n=001 at edge 10, 011 at edge 14, 111 at edge 18; seq_done high only at edge 18; seq_busy falls at edge 18; stage_idx steps 1, 2, 3.
- soft_rst_n low for 2 cycles in RUN -> no change. soft_rst_n low for 3 cycles -> rst_n=000 and seq_busy=1 on the edge after soft_req rises; after release, rst_n[0] rises 8 edges after go returns.
- pll_locked falls when rst_n=001 -> rst_n=000 3 edges later, no seq_done; on relock, the full 8/4/4 sequence restarts from domain 0.
- reset1 pulsed low asynchronously mid-STAGE -> outputs reach reset values with no clock edge; the sequence restarts from WAIT.
- Loss of lock on the same edge a release is due -> the release is suppressed and all rst_n=0.
- STAGES=1 build -> rst_n[0] and seq_done rise together at edge E+INIT_DLY; stage_idx goes 0 to 1.
